// File: rtl/nlc_horner_sequencer.sv
// nlc_horner_sequencer
//
// Evaluates the ADC non-linearity correction polynomial for one sample. One
// external float adder and one external float multiplier are shared: the
// sample is first preconditioned as xn = (x + negmean) * invstd, then the
// section polynomial c[0]*xn^(n-1) + ... + c[n-1] is evaluated by Horner's
// rule. Only one arithmetic unit is ever in flight.
//
// Ports
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   i_srdyi, i_x, i_section start request with sample and section (0..3)
//   o_busy                  sequencer not idle
//   o_srdyo, o_y            one-cycle done pulse; o_y holds the last result
//   o_err                   one-cycle pulse when a unit fails to answer in time
//   o_rom_addr, i_rom_data  {section, idx}: idx 0..7 = c[idx], 8 = negmean,
//                           9 = invstd; ROM data is combinational
//   o_add_*, i_add_*        adder operands/start and result/done
//   o_mul_*, i_mul_*        multiplier operands/start and result/done

module nlc_horner_sequencer #(
  parameter int P_NCOEF0  = 7,
  parameter int P_NCOEF1  = 6,
  parameter int P_NCOEF2  = 6,
  parameter int P_NCOEF3  = 7,
  parameter int P_TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_srdyi,
  input  logic [31:0] i_x,
  input  logic [1:0]  i_section,
  output logic        o_busy,
  output logic        o_srdyo,
  output logic        o_err,
  output logic [31:0] o_y,
  output logic [5:0]  o_rom_addr,
  input  logic [31:0] i_rom_data,
  output logic [31:0] o_add_x,
  output logic [31:0] o_add_y,
  output logic        o_add_srdyi,
  input  logic [31:0] i_add_z,
  input  logic        i_add_srdyo,
  output logic [31:0] o_mul_x,
  output logic [31:0] o_mul_y,
  output logic        o_mul_srdyi,
  input  logic [31:0] i_mul_z,
  input  logic        i_mul_srdyo
);

  localparam int              CNT_W       = $clog2(P_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(P_TIMEOUT - 1);
  localparam logic [3:0]      IDX_NEGMEAN = 4'd8;
  localparam logic [3:0]      IDX_INVSTD  = 4'd9;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRE_ADD,
    S_PRE_ADD_W,
    S_PRE_MUL,
    S_PRE_MUL_W,
    S_H_MUL,
    S_H_MUL_W,
    S_H_ADD,
    S_H_ADD_W,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [1:0]       section_q;
  logic [3:0]       n_q;
  logic [3:0]       k_q;
  logic [31:0]      xn_q;
  logic [31:0]      acc_q;
  logic [31:0]      y_q;
  logic [31:0]      add_x_q;
  logic [31:0]      add_y_q;
  logic [31:0]      mul_x_q;
  logic [31:0]      mul_y_q;
  logic [CNT_W-1:0] wait_cnt;
  logic [3:0]       rom_idx;
  logic             in_wait;
  logic             unit_done;
  logic             timeout_hit;

  function automatic logic [3:0] coef_count(input logic [1:0] sec);
    case (sec)
      2'd0:    return 4'(P_NCOEF0);
      2'd1:    return 4'(P_NCOEF1);
      2'd2:    return 4'(P_NCOEF2);
      default: return 4'(P_NCOEF3);
    endcase
  endfunction

  // The done strobe that matters depends on which unit the current wait
  // state is waiting for; strobes seen in any other state are ignored.
  always_comb begin
    in_wait   = 1'b0;
    unit_done = 1'b0;
    case (state)
      S_PRE_ADD_W, S_H_ADD_W: begin
        in_wait   = 1'b1;
        unit_done = i_add_srdyo;
      end
      S_PRE_MUL_W, S_H_MUL_W: begin
        in_wait   = 1'b1;
        unit_done = i_mul_srdyo;
      end
      default: ;
    endcase
    timeout_hit = (wait_cnt == CNT_LAST);
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A wait state that runs out of time drops back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (i_srdyi) state_next = S_PRE_ADD;
      S_PRE_ADD:   state_next = S_PRE_ADD_W;
      S_PRE_ADD_W: begin
        if (unit_done)        state_next = S_PRE_MUL;
        else if (timeout_hit) state_next = S_IDLE;
      end
      S_PRE_MUL:   state_next = S_PRE_MUL_W;
      S_PRE_MUL_W: begin
        if (unit_done)        state_next = (n_q == 4'd1) ? S_DONE : S_H_MUL;
        else if (timeout_hit) state_next = S_IDLE;
      end
      S_H_MUL:     state_next = S_H_MUL_W;
      S_H_MUL_W: begin
        if (unit_done)        state_next = S_H_ADD;
        else if (timeout_hit) state_next = S_IDLE;
      end
      S_H_ADD:     state_next = S_H_ADD_W;
      S_H_ADD_W: begin
        if (unit_done)        state_next = (k_q == n_q - 4'd1) ? S_DONE : S_H_MUL;
        else if (timeout_hit) state_next = S_IDLE;
      end
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // Output decode. Operand registers are loaded on the edge that enters an
  // issue state, so the ROM index one state ahead points at the word the
  // next issue needs (IDLE already addresses negmean of the incoming section).
  always_comb begin
    rom_idx     = 4'd0;
    o_add_srdyi = 1'b0;
    o_mul_srdyi = 1'b0;
    o_srdyo     = 1'b0;
    case (state)
      S_IDLE:      rom_idx = IDX_NEGMEAN;
      S_PRE_ADD: begin
        rom_idx     = IDX_NEGMEAN;
        o_add_srdyi = 1'b1;
      end
      S_PRE_ADD_W: rom_idx = IDX_INVSTD;
      S_PRE_MUL: begin
        rom_idx     = IDX_INVSTD;
        o_mul_srdyi = 1'b1;
      end
      S_PRE_MUL_W: rom_idx = 4'd0;
      S_H_MUL: begin
        rom_idx     = k_q;
        o_mul_srdyi = 1'b1;
      end
      S_H_MUL_W:   rom_idx = k_q;
      S_H_ADD: begin
        rom_idx     = k_q;
        o_add_srdyi = 1'b1;
      end
      S_H_ADD_W:   rom_idx = k_q;
      S_DONE:      o_srdyo = 1'b1;
      default: ;
    endcase
    o_err = in_wait && !unit_done && timeout_hit;
  end

  assign o_rom_addr = {(state == S_IDLE) ? i_section : section_q, rom_idx};
  assign o_busy     = (state != S_IDLE);
  assign o_y        = (state == S_DONE) ? acc_q : y_q;
  assign o_add_x    = add_x_q;
  assign o_add_y    = add_y_q;
  assign o_mul_x    = mul_x_q;
  assign o_mul_y    = mul_y_q;

  // Datapath. Each unit result is copied straight into the operands of the
  // next issue; the multiplier x operand doubles as the preconditioning
  // temporary t. The wait counter restarts on every issue cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      section_q <= '0;
      n_q       <= '0;
      k_q       <= '0;
      xn_q      <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      add_x_q   <= '0;
      add_y_q   <= '0;
      mul_x_q   <= '0;
      mul_y_q   <= '0;
      wait_cnt  <= '0;
    end else begin
      if (in_wait) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      case (state)
        S_IDLE: begin
          if (i_srdyi) begin
            section_q <= i_section;
            n_q       <= coef_count(i_section);
            k_q       <= 4'd1;
            add_x_q   <= i_x;
            add_y_q   <= i_rom_data;
          end
        end
        S_PRE_ADD_W: begin
          if (unit_done) begin
            mul_x_q <= i_add_z;
            mul_y_q <= i_rom_data;
          end
        end
        S_PRE_MUL_W: begin
          if (unit_done) begin
            xn_q    <= i_mul_z;
            acc_q   <= i_rom_data;
            mul_x_q <= i_rom_data;
            mul_y_q <= i_mul_z;
          end
        end
        S_H_MUL_W: begin
          if (unit_done) begin
            acc_q   <= i_mul_z;
            add_x_q <= i_mul_z;
            add_y_q <= i_rom_data;
          end
        end
        S_H_ADD_W: begin
          if (unit_done) begin
            acc_q   <= i_add_z;
            k_q     <= k_q + 4'd1;
            mul_x_q <= i_add_z;
            mul_y_q <= xn_q;
          end
        end
        S_DONE: y_q <= acc_q;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/nlc_horner_sequencer.md
Name: nlc_horner_sequencer

Overview:
- Controller that time-shares one smc_float_adder and one smc_float_multiplier to evaluate the ADC non-linearity correction polynomial for one sample.
- Per sample it does two things:
  - preconditions the input as xn = (x + negmean) * invstd;
  - evaluates the section's polynomial in xn by Horner's rule.
- Section constants come from an external combinational coefficient ROM.
- Sits between the fp_to_smc_float converter/section decoder and the NLC output register.

Parameters:
- P_NCOEF0, 7: coefficient count for section 0 (range 1..8).
- P_NCOEF1, 6: coefficient count for section 1.
- P_NCOEF2, 6: coefficient count for section 2.
- P_NCOEF3, 7: coefficient count for section 3.
- P_TIMEOUT, 64: maximum cycles spent waiting for any unit's srdyo before the operation is aborted.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_srdyi  in  1  start request; x and section are valid
- i_x  in  32  SMC float sample
- i_section  in  2  polynomial section 0..3
- o_busy  out  1  sequencer not idle
- o_srdyo  out  1  one-cycle pulse; o_y valid
- o_err  out  1  one-cycle pulse; timeout abort
- o_y  out  32  corrected value, held until next o_srdyo
- o_rom_addr  out  6  {section[1:0], idx[3:0]}; idx 0..7 = coefficient c[idx] (c[0] highest order), idx 8 = negmean, idx 9 = invstd
- i_rom_data  in  32  ROM word, combinational on o_rom_addr
- o_add_x, o_add_y  out  32  adder operands
- o_add_srdyi  out  1  adder start
- i_add_z  in  32  adder result
- i_add_srdyo  in  1  adder done
- o_mul_x, o_mul_y  out  32  multiplier operands
- o_mul_srdyi  out  1  multiplier start
- i_mul_z  in  32  multiplier result
- i_mul_srdyo  in  1  multiplier done

Behaviour:
- Reset (async, i_reset_n=0):
  - state goes to IDLE;
  - o_busy, o_srdyo, o_err, o_add_srdyi and o_mul_srdyi are 0;
  - o_y, all operand outputs and internal registers are 0.
- Reset mid-operation discards the operation; any unit result arriving later is ignored.
- States and transitions:
  - IDLE: when i_srdyi=1, capture i_x and i_section, set n = P_NCOEF[section] and k = 1, then go to PRE_ADD.
  - PRE_ADD: drive o_add_x = x, o_add_y = ROM[negmean], o_add_srdyi = 1 for this cycle only. Go to PRE_ADD_W.
  - PRE_ADD_W: on i_add_srdyo, t <= i_add_z, go to PRE_MUL.
  - PRE_MUL: drive o_mul_x = t, o_mul_y = ROM[invstd], 1-cycle o_mul_srdyi. Go to PRE_MUL_W.
  - PRE_MUL_W: o_rom_addr selects c[0]. On i_mul_srdyo: xn <= i_mul_z, acc <= c[0]. Then go to DONE if n == 1, else to H_MUL.
  - H_MUL: drive o_mul = (acc, xn) with a 1-cycle srdyi. Go to H_MUL_W.
  - H_MUL_W: on srdyo, acc <= i_mul_z, go to H_ADD.
  - H_ADD: drive o_add = (acc, ROM c[k]) with a 1-cycle srdyi. Go to H_ADD_W.
  - H_ADD_W: on srdyo, acc <= i_add_z and k <= k+1. Then go to DONE if k == n-1, else to H_MUL.
  - DONE: o_y <= acc and o_srdyo = 1 for one cycle. Go to IDLE.
- Handshake rules:
  - Operand outputs are held stable from the issue cycle until the matching srdyo is sampled.
  - srdyi is never reasserted before the prior srdyo.
  - srdyo is sampled only in the matching _W state; srdyo in any other state or cycle is ignored.
  - Only one unit is ever in flight.
- i_srdyi is ignored while o_busy=1 (state != IDLE, DONE included); no queuing.
- i_x and i_section changes after capture have no effect.
- o_rom_addr:
  - tracks the captured section plus the operand index required by the current state;
  - is {i_section, 8} in IDLE.
- Latency:
  - With adder latency La and multiplier latency Lm (srdyo is asserted La/Lm cycles after the issue cycle), start accepted at cycle 0 gives o_srdyo at cycle 1 + n*(La+Lm+2).
  - Example: La = Lm = 1 gives 29 cycles for n=7 and 25 cycles for n=6.
- Timeout:
  - The wait counter clears on every issue cycle.
  - If a _W state accumulates P_TIMEOUT cycles without srdyo: pulse o_err for 1 cycle, go to IDLE, leave o_y unchanged, no o_srdyo.
- Arithmetic: all values are passed through unmodified as 32-bit SMC floats; the sequencer performs no arithmetic of its own.

Test Plan:
- Bench setup: ideal float adder/multiplier models with La = Lm = 1. ROM holds IEEE-encoded values: negmean = 0.0, invstd = 1.0, all coefficients = 1.0.
- Section 1, x = 2.0 (0x40000000), start at cycle 0 -> o_srdyo at cycle 25, o_y = 63.0 (0x427C0000), o_busy low at cycle 26.
- Section 0, x = 1.0, negmean = -1.0, invstd = 0.5 -> xn = 0, o_y = 1.0 (0x3F800000) at cycle 29. Bench checks that exactly 7 adds and 7 multiplies are issued.
- Set P_NCOEF2 = 1, x arbitrary -> o_srdyo at cycle 1+(La+Lm+2) = 5, o_y = c[0], no H_ state entered.
- Pulse i_srdyi every cycle during a run and vary i_x -> only the first request is served, and the result matches the first captured x.
- Multiplier model never asserts srdyo -> o_err pulse P_TIMEOUT cycles after the PRE_MUL issue, o_y keeps its prior value, next start completes normally.
- Deassert i_reset_n during H_ADD_W -> all outputs are 0 immediately. A late i_add_srdyo after release is ignored, and a new start gives the correct result.
